// File: rtl/commit_mem_port_pkg.sv
// rtl/commit_mem_port_pkg.sv - shared widths, IO window and state encoding for the commit memory port
package commit_mem_port_pkg;

    localparam int          CMP_ADDR_W  = 32;
    localparam int          CMP_DATA_W  = 32;
    localparam logic [31:0] CMP_IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        CMP_IDLE,
        CMP_WR,
        CMP_RD,
        CMP_RD_TAIL
    } cmp_state_t;

    // Index of the final byte of an access; anything but 1 or 2 bytes is a word.
    function automatic logic [1:0] size_last(input logic [5:0] size);
        case (size)
            6'd1:    size_last = 2'd0;
            6'd2:    size_last = 2'd1;
            default: size_last = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/commit_mem_port_if.sv
// rtl/commit_mem_port_if.sv - byte-wide RAM/IO bus shared with fetch through the arbiter
interface commit_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic              io_buffer_full;

    modport master (
        output bus_req, mem_a, mem_dout, mem_wr,
        input  bus_gnt, mem_din, io_buffer_full
    );

    modport slave (
        input  bus_req, mem_a, mem_dout, mem_wr,
        output bus_gnt, mem_din, io_buffer_full
    );
endinterface

// File: rtl/commit_mem_port_load_extend.sv
// rtl/commit_mem_port_load_extend.sv - sign/zero extension of an assembled little-endian load
module commit_mem_port_load_extend (
    input  logic [31:0] raw,
    input  logic [1:0]  last,
    input  logic        sgn,
    output logic [31:0] ext
);
    always_comb begin
        ext = raw;
        case (last)
            2'd0:    ext = {{24{sgn & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{16{sgn & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/commit_mem_port.sv
// rtl/commit_mem_port.sv - serializes committed stores and IO loads onto the byte-wide memory bus
module commit_mem_port
    import commit_mem_port_pkg::*;
#(
    parameter int                ADDR_W  = CMP_ADDR_W,
    parameter int                DATA_W  = CMP_DATA_W,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(CMP_IO_BASE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_out_mem,
    input  logic [5:0]        out_mem_size,
    input  logic [ADDR_W-1:0] out_mem_addr,
    input  logic [DATA_W-1:0] out_mem_data,
    input  logic              if_out_mem_io,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [2:0]        io_size,
    input  logic              io_signed,
    output logic              if_stored,
    output logic              if_get_mem,
    output logic [DATA_W-1:0] data_mem,
    commit_mem_port_if.master bus
);
    cmp_state_t        state, state_n;
    logic [1:0]        cnt, cnt_n, last, last_n, pidx, pidx_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] data, data_n, data_mem_n;
    logic              sgn, sgn_n, pend, pend_n;
    logic              stored_n, get_n;
    logic [31:0]       rbuf, rbuf_n, assembled, extended;
    logic              in_wr, in_rd, io_blocked, issue;

    assign in_wr      = (state == CMP_WR);
    assign in_rd      = (state == CMP_RD);
    // Only IO writes back off on a full sink; IO reads are never held.
    assign io_blocked = in_wr && (addr >= IO_BASE) && bus.io_buffer_full;
    assign issue      = (in_wr || in_rd) && bus.bus_gnt && rdy && !io_blocked;

    assign bus.bus_req  = in_wr || in_rd;
    assign bus.mem_wr   = issue && in_wr;
    assign bus.mem_a    = issue ? addr + ADDR_W'(cnt) : '0;
    assign bus.mem_dout = in_wr ? data[{cnt, 3'b000} +: 8] : 8'h00;

    // The byte read last cycle lands on mem_din now, even when the bus is frozen.
    always_comb begin
        assembled = rbuf;
        if (pend) assembled[{pidx, 3'b000} +: 8] = bus.mem_din;
    end

    commit_mem_port_load_extend u_load_extend (
        .raw  (assembled),
        .last (last),
        .sgn  (sgn),
        .ext  (extended)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_n     = last;
        pidx_n     = pidx;
        addr_n     = addr;
        data_n     = data;
        sgn_n      = sgn;
        pend_n     = 1'b0;
        rbuf_n     = assembled;
        stored_n   = 1'b0;
        get_n      = 1'b0;
        data_mem_n = data_mem;
        if (rdy) begin
            case (state)
                CMP_IDLE: begin
                    if (if_out_mem) begin
                        state_n = CMP_WR;
                        cnt_n   = 2'd0;
                        addr_n  = out_mem_addr;
                        data_n  = out_mem_data;
                        last_n  = size_last(out_mem_size);
                    end else if (if_out_mem_io) begin
                        state_n = CMP_RD;
                        cnt_n   = 2'd0;
                        addr_n  = io_addr;
                        last_n  = size_last({3'b000, io_size});
                        sgn_n   = io_signed;
                        rbuf_n  = '0;
                    end
                end
                CMP_WR: begin
                    if (issue) begin
                        if (cnt == last) begin
                            state_n  = CMP_IDLE;
                            cnt_n    = 2'd0;
                            stored_n = 1'b1;
                        end else begin
                            cnt_n = cnt + 2'd1;
                        end
                    end
                end
                CMP_RD: begin
                    if (clear) begin
                        state_n = CMP_IDLE;
                        cnt_n   = 2'd0;
                    end else if (issue) begin
                        pend_n = 1'b1;
                        pidx_n = cnt;
                        if (cnt == last) begin
                            state_n = CMP_RD_TAIL;
                            cnt_n   = 2'd0;
                        end else begin
                            cnt_n = cnt + 2'd1;
                        end
                    end
                end
                CMP_RD_TAIL: begin
                    state_n = CMP_IDLE;
                    if (!clear) begin
                        data_mem_n = extended;
                        get_n      = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CMP_IDLE;
            cnt        <= 2'd0;
            last       <= 2'd0;
            pidx       <= 2'd0;
            addr       <= '0;
            data       <= '0;
            sgn        <= 1'b0;
            pend       <= 1'b0;
            rbuf       <= '0;
            if_stored  <= 1'b0;
            if_get_mem <= 1'b0;
            data_mem   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last       <= last_n;
            pidx       <= pidx_n;
            addr       <= addr_n;
            data       <= data_n;
            sgn        <= sgn_n;
            pend       <= pend_n;
            rbuf       <= rbuf_n;
            if_stored  <= stored_n;
            if_get_mem <= get_n;
            data_mem   <= data_mem_n;
        end
    end
endmodule
